// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

  // Arbiter FSM: IDLE spends one bubble choosing an owner, GRANT streams its beats
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Ceiling log2 usable in constant expressions (result is 0 for values <= 1)
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam int DEF_N_REQ = 4;
  localparam int DEF_IDW   = clog2(DEF_N_REQ);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - round-robin picker: rotate, priority-encode, un-rotate
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IDW   = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   rr_last,
  output logic             found,
  output logic [IDW-1:0]   idx
);

  // One extra bit so rr_last+1 == N_REQ is representable before wrapping
  localparam int SW = IDW + 1;
  localparam logic [SW:0] NQ = (SW+1)'(N_REQ);

  logic [SW-1:0]    w_start;
  logic [SW-1:0]    w_off;
  logic [N_REQ-1:0] w_rot;
  logic [SW:0]      w_sum;

  // Rotate so bit 0 of w_rot is the requester right after the last owner
  assign w_start = {1'b0, rr_last} + SW'(1);
  assign w_rot   = N_REQ'({req, req} >> w_start);

  // Priority-encode the lowest set bit of the rotated request vector
  always_comb begin
    w_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = SW'(k);
    end
  end

  // Un-rotate: offset back to an absolute index, modulo N_REQ
  assign w_sum = {1'b0, w_start} + {1'b0, w_off};
  assign idx   = (w_sum >= NQ) ? IDW'(w_sum - NQ) : IDW'(w_sum);
  assign found = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, packet-atomic, burst-capped arbiter for a FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ     = DEF_N_REQ,
  parameter  int PW        = 8,
  parameter  int MAX_BURST = 8,
  localparam int IDW       = clog2(N_REQ)
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                arb_en,
  input  logic [N_REQ-1:0]    in_valid,
  input  logic [N_REQ-1:0]    in_last,
  input  logic [N_REQ*PW-1:0] in_data,
  output logic [N_REQ-1:0]    in_ready,
  output logic                wreq,
  output logic [IDW+PW-1:0]   wdata,
  input  logic                wfull,
  output logic [IDW-1:0]      gnt_id,
  output logic                busy
);

  // Counter reaches MAX_BURST at most (release fires at MAX_BURST-1), so it never wraps
  localparam int CW = clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(MAX_BURST - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDW-1:0]   r_gnt_id;
  logic [IDW-1:0]   r_rr_last;
  logic [CW-1:0]    r_beat_cnt;

  logic             w_pick_found;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_sel_valid;
  logic             w_sel_last;
  logic [PW-1:0]    w_sel_data;
  logic [N_REQ-1:0] w_gnt_onehot;
  logic             w_granted;
  logic             w_beat;
  logic             w_release;
  logic             w_take_grant;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req     (in_valid),
    .rr_last (r_rr_last),
    .found   (w_pick_found),
    .idx     (w_pick_idx)
  );

  // Route the current owner's valid/last/payload and build its one-hot ready mask
  always_comb begin
    w_sel_valid  = 1'b0;
    w_sel_last   = 1'b0;
    w_sel_data   = '0;
    w_gnt_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_gnt_id == IDW'(i)) begin
        w_sel_valid     = in_valid[i];
        w_sel_last      = in_last[i];
        w_sel_data      = in_data[i*PW +: PW];
        w_gnt_onehot[i] = 1'b1;
      end
    end
  end

  // A beat moves only while granted, the owner is valid and the FIFO has room;
  // the grant ends on that same beat at end-of-packet or at the burst cap
  assign w_granted = (r_state == GRANT);
  assign w_beat    = w_granted & w_sel_valid & ~wfull;
  assign w_release = w_beat & (w_sel_last | (r_beat_cnt == CAP_LAST));

  // Next-state: IDLE grants when enabled and someone is valid; GRANT holds until release
  always_comb begin
    w_state_nxt  = r_state;
    w_take_grant = 1'b0;
    case (r_state)
      IDLE: begin
        if (arb_en && w_pick_found) begin
          w_state_nxt  = GRANT;
          w_take_grant = 1'b1;
        end
      end
      GRANT: begin
        if (w_release) w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Owner and burst counter: loaded on a new grant, counted per accepted beat
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_gnt_id   <= '0;
      r_beat_cnt <= '0;
    end else if (w_take_grant) begin
      r_gnt_id   <= w_pick_idx;
      r_beat_cnt <= '0;
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + CW'(1);
    end
  end

  // Round-robin pointer: remembers the owner that just released (reset gives requester 0 first turn)
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)        r_rr_last <= IDW'(N_REQ - 1);
    else if (w_release) r_rr_last <= r_gnt_id;
  end

  assign in_ready = (w_granted & ~wfull) ? w_gnt_onehot : '0;
  assign wreq     = w_beat;
  assign wdata    = w_beat ? {r_gnt_id, w_sel_data} : '0;
  assign gnt_id   = r_gnt_id;
  assign busy     = w_granted;

endmodule
